// File: rtl/can_tx_serializer_pkg.sv
// can_pkg: shared CAN bit-level types, constants and bit-timing helper.
package can_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STUFF = 2'd2
    } can_tx_state_t;

    localparam int unsigned CAN_STUFF_LIMIT = 5;
    localparam logic        CAN_RECESSIVE   = 1'b1;

    // System clock cycles per nominal CAN bit
    function automatic int unsigned can_bit_cycles(input int unsigned clk_mhz,
                                                   input int unsigned bitrate_kbps);
        return (clk_mhz * 32'd1000) / bitrate_kbps;
    endfunction

endpackage

// File: rtl/can_tx_serializer_if.sv
// Bit-stream handshake from the frame builder plus the serial line status.
interface can_tx_serializer_if;
    logic en;
    logic din;
    logic din_valid;
    logic din_ready;
    logic tx;
    logic bit_start;
    logic stuff;
    logic busy;
    logic underrun;

    modport master (
        output en, din, din_valid,
        input  din_ready, tx, bit_start, stuff, busy, underrun
    );

    modport slave (
        input  en, din, din_valid,
        output din_ready, tx, bit_start, stuff, busy, underrun
    );
endinterface

// File: rtl/can_tx_serializer_bit_timer.sv
// can_bit_timer: nominal bit period counter with restart and end-of-bit flag.
module can_bit_timer #(
    parameter  int unsigned BIT_CYCLES = 100,
    localparam int unsigned CNT_W      = $clog2(BIT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_bit_end
);

    logic [CNT_W-1:0] r_cnt;

    assign o_bit_end = (r_cnt == CNT_W'(BIT_CYCLES - 1));

    // Count through one bit period, wrapping so back-to-back bits stay aligned
    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt <= '0;
        end else if (o_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/can_tx_serializer.sv
// can_tx_serializer: CAN bit transmitter with optional stuff-bit insertion.
// Stuffing is built only when CAN_TX_STUFF_EN is defined.
module can_tx_serializer
    import can_pkg::*;
#(
    parameter int unsigned CLK_MHZ      = 100,
    parameter int unsigned BITRATE_KBPS = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    can_tx_serializer_if.slave    bus
);

    localparam int unsigned BIT_CYCLES = can_bit_cycles(CLK_MHZ, BITRATE_KBPS);

    if (BIT_CYCLES < 2) begin : g_bad_bit_cycles
        $error("can_tx_serializer: BIT_CYCLES must be at least 2");
    end

    can_tx_state_t r_state;
    can_tx_state_t w_state_nxt;

    logic w_bit_end;
    logic w_ready;
    logic w_xfer;
    logic w_stuff_due;
    logic w_stuff_bit;
    logic w_go_stuff;
    logic w_underrun;

    logic r_tx;
    logic r_bit_start;
    logic r_stuff;
    logic r_busy;
    logic w_tx_nxt;
    logic w_bit_start_nxt;
    logic w_stuff_nxt;
    logic w_busy_nxt;

    can_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (r_state == IDLE),
        .o_bit_end (w_bit_end)
    );

    // Accept a bit when idle, or at a boundary that is not followed by a stuff bit
    assign w_ready    = !rst && bus.en && ((r_state == IDLE) || (w_bit_end && !w_stuff_due));
    assign w_xfer     = bus.din_valid && w_ready;
    assign w_go_stuff = !rst && bus.en && w_bit_end && w_stuff_due;
    assign w_underrun = !rst && bus.en && (r_state != IDLE) && w_bit_end
                        && !w_stuff_due && !bus.din_valid;

`ifdef CAN_TX_STUFF_EN
    localparam int unsigned RUN_W = 3;

    logic             r_last;
    logic [RUN_W-1:0] r_run;

    assign w_stuff_due = (r_state == DATA) && (r_run == RUN_W'(CAN_STUFF_LIMIT));
    assign w_stuff_bit = ~r_last;

    // Track the current run of equal line bits; stuff bits start a new run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= CAN_RECESSIVE;
            r_run  <= '0;
        end else if (w_go_stuff) begin
            r_last <= ~r_last;
            r_run  <= RUN_W'(1);
        end else if (w_xfer) begin
            if ((r_state != IDLE) && (bus.din == r_last)) begin
                r_run <= r_run + RUN_W'(1);
            end else begin
                r_run  <= RUN_W'(1);
                r_last <= bus.din;
            end
        end else if (r_state == IDLE) begin
            r_run <= '0;
        end
    end
`else
    assign w_stuff_due = 1'b0;
    assign w_stuff_bit = CAN_RECESSIVE;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode at idle and bit boundaries
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_bit_end) begin
                    if (w_go_stuff)  w_state_nxt = STUFF;
                    else if (w_xfer) w_state_nxt = DATA;
                    else             w_state_nxt = IDLE;
                end
            end
`ifdef CAN_TX_STUFF_EN
            STUFF: begin
                if (w_bit_end) w_state_nxt = w_xfer ? DATA : IDLE;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered line outputs
    always_comb begin
        w_tx_nxt        = r_tx;
        w_bit_start_nxt = w_xfer || w_go_stuff;
        w_busy_nxt      = (w_state_nxt != IDLE);
`ifdef CAN_TX_STUFF_EN
        w_stuff_nxt     = (w_state_nxt == STUFF);
`else
        w_stuff_nxt     = 1'b0;
`endif
        if (w_state_nxt == IDLE) w_tx_nxt = CAN_RECESSIVE;
        else if (w_xfer)         w_tx_nxt = bus.din;
        else if (w_go_stuff)     w_tx_nxt = w_stuff_bit;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx        <= CAN_RECESSIVE;
            r_bit_start <= 1'b0;
            r_stuff     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_tx        <= w_tx_nxt;
            r_bit_start <= w_bit_start_nxt;
            r_stuff     <= w_stuff_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.tx        = r_tx;
    assign bus.bit_start = r_bit_start;
    assign bus.stuff     = r_stuff;
    assign bus.busy      = r_busy;
    assign bus.din_ready = w_ready;
    assign bus.underrun  = w_underrun;

endmodule

// File: tb/tb_can_tx_serializer.sv
// tb_can_tx_serializer: random and directed frames against a CAN line model.
module tb_can_tx_serializer;
    import can_pkg::*;

    localparam int BC = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    can_tx_serializer_if bus ();

    can_tx_serializer #(.CLK_MHZ(100), .BITRATE_KBPS(1000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cur_c = 0;

    bit frame_q[$];
    bit line_b[$];
    bit line_s[$];

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cur_c, got, exp);
        end
    endtask

    // Line bits as CAN puts them on the wire: complement after five equal bits
    function automatic void build_line();
        int run = 0;
        bit last = 1'b0;
        line_b.delete();
        line_s.delete();
        foreach (frame_q[i]) begin
            if (run != 0 && frame_q[i] == last) run++;
            else begin run = 1; last = frame_q[i]; end
            line_b.push_back(frame_q[i]);
            line_s.push_back(1'b0);
`ifdef CAN_TX_STUFF_EN
            if (run == int'(CAN_STUFF_LIMIT)) begin
                line_b.push_back(~last);
                line_s.push_back(1'b1);
                last = ~last;
                run  = 1;
            end
`endif
        end
    endfunction

    // Stream frame_q starting at the first idle cycle; d = cycle en drops, r = reset cycle (0 = none)
    task automatic run_frame(input int d, input int r);
        int n, len, m, e_end, c_end, idx;
        bit ur_end;
        build_line();
        n   = frame_q.size();
        len = line_b.size();
        m   = len;
        if (d > 0 && ((d + BC - 1) / BC) < m) m = (d + BC - 1) / BC;
        e_end  = m * BC;
        ur_end = (d == 0) || (d > e_end);
        c_end  = ((r > 0) ? r : e_end) + 3;
        idx    = 0;
        for (int c = 0; c <= c_end; c++) begin
            logic e_tx, e_bs, e_st, e_busy, e_ur, e_rdy, en_c, rst_c, bnd;
            int k;
            @(negedge clk);
            en_c  = !(d > 0 && c >= d);
            rst_c = (r > 0 && c == r);
            bus.en        = en_c;
            rst           = rst_c;
            bus.din_valid = (idx < n) && !(r > 0 && c >= r);
            bus.din       = (idx < n) ? frame_q[idx] : 1'($urandom);
            #1;
            cur_c = c;
            if (c >= 1 && c <= e_end && !(r > 0 && c > r)) begin
                k      = (c - 1) / BC;
                bnd    = (c % BC) == 0;
                e_tx   = line_b[k];
                e_st   = line_s[k];
                e_bs   = ((c - 1) % BC) == 0;
                e_busy = 1'b1;
                e_ur   = bnd && (c == e_end) && ur_end;
                e_rdy  = en_c && bnd && ((c == e_end) || !line_s[c / BC]);
            end else begin
                e_tx = 1'b1; e_st = 1'b0; e_bs = 1'b0; e_busy = 1'b0; e_ur = 1'b0;
                e_rdy = en_c;
            end
            if (rst_c) begin
                e_rdy = 1'b0;
                e_ur  = 1'b0;
            end
            check_bit("tx",        bus.tx,        e_tx);
            check_bit("bit_start", bus.bit_start, e_bs);
            check_bit("stuff",     bus.stuff,     e_st);
            check_bit("busy",      bus.busy,      e_busy);
            check_bit("underrun",  bus.underrun,  e_ur);
            check_bit("din_ready", bus.din_ready, e_rdy);
            if (bus.din_valid && e_rdy) idx++;
        end
        rst = 1'b0;
    endtask

    task automatic set_frame(input int n, input int mode);
        bit b;
        frame_q.delete();
        b = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       ;
                1:       b = 1'($urandom);
                2:       if ($urandom_range(0, 5) == 0) b = ~b;
                default: b = ~b;
            endcase
            frame_q.push_back(b);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b1;
        bus.din_valid = 1'b1;
        bus.din = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_bit("rst_tx",        bus.tx,        1'b1);
            check_bit("rst_din_ready", bus.din_ready, 1'b0);
            check_bit("rst_busy",      bus.busy,      1'b0);
            check_bit("rst_bit_start", bus.bit_start, 1'b0);
            check_bit("rst_stuff",     bus.stuff,     1'b0);
            check_bit("rst_underrun",  bus.underrun,  1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.din_valid = 1'b0;

        frame_q = '{1'b1, 1'b0, 1'b1};
        run_frame(250, 0);
        frame_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_frame(0, 0);
        frame_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_frame(0, 0);
        frame_q = '{1'b1, 1'b0};
        run_frame(0, 0);
        frame_q = '{1'b0, 1'b1, 1'b1, 1'b0};
        run_frame(150, 0);
        frame_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_frame(0, 550);
        frame_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        run_frame(0, 0);

        for (int f = 0; f < 14; f++) begin
            int n, d, r;
            n = int'($urandom_range(1, 10));
            set_frame(n, int'($urandom_range(0, 3)));
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n * BC + 150)) : 0;
            r = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, n * BC)) : 0;
            run_frame(d, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
